din_qualify_ctrl: RTL and testbench
===================================

Name: din_qualify_ctrl

Overview:
Sequencing controller for the registered capture path: an input flop pair gated by an AND2 into an output flop, with an inverted tap. It synchronizes an asynchronous data input and qualifies it with a configurable run-length filter. It then issues a one-cycle capture pulse and a qualified level, and enforces a hold-off window before re-arming. It sits between the raw pin and the capture flops and is the only block that drives their gate and enable.

Parameters:
CNT_W, 8, width of run-length and hold-off counters and config inputs
EVT_W, 8, width of the qualified-event counter

Ports:
CLK  input  1  single system clock, rising edge
RESETN  input  1  synchronous active-low reset, sampled on CLK rising edge
EN  input  1  controller enable; low forces IDLE
D_IN  input  1  asynchronous raw data input
QUAL_LEN  input  CNT_W  consecutive-high samples required (0 treated as 1)
HOLD_LEN  input  CNT_W  hold-off cycles after release (0 treated as 1)
CLR_CNT  input  1  synchronous clear of EVT_CNT
Q_PULSE  output  1  one-cycle capture strobe on qualification
Q_LEVEL  output  1  qualified level, high while in ASSERT
Q_N  output  1  registered inverse of Q_LEVEL
BUSY  output  1  high in COUNT, ASSERT or HOLDOFF
STATE  output  2  IDLE=0, COUNT=1, ASSERT=2, HOLDOFF=3
EVT_CNT  output  EVT_W  number of qualified events, wraps modulo 2^EVT_W

Behaviour:
- Reset (RESETN low at an edge): sync flops=0, STATE=IDLE, counters=0, Q_PULSE=0, Q_LEVEL=0, Q_N=1, BUSY=0, EVT_CNT=0. Reset overrides all inputs, including mid-operation.
- Synchronizer: D_IN passes through two flops (s1, s2). The FSM acts only on s2, giving 2 cycles of input latency.
- All outputs are registered and updated at the same edge as the state transition.
- Config latch: QUAL_LEN and HOLD_LEN are captured into L and H at the edge that leaves IDLE. Changes while BUSY have no effect until the next IDLE exit.
- IDLE:
  - EN=1 and s2=1: if L==1, go to ASSERT; else go to COUNT with run=1.
  - Otherwise stay in IDLE.
- COUNT:
  - s2=0: go to IDLE, run=0. A glitch shorter than L never qualifies.
  - s2=1: run+1. When run+1==L, go to ASSERT.
- ASSERT entry edge: Q_PULSE=1 for exactly one cycle, Q_LEVEL=1, Q_N=0, EVT_CNT+1.
- ASSERT: stay while s2=1, with no further pulses. On s2=0, go to HOLDOFF with hcnt=1, Q_LEVEL=0, Q_N=1.
- HOLDOFF: ignores s2 and occupies exactly H cycles. At the edge where hcnt==H, go to IDLE; otherwise hcnt+1.
- Re-arm: input still high after HOLDOFF restarts qualification from IDLE, so no back-to-back pulse inside the hold-off window.
- EN=0 at any edge: go to IDLE next edge, counters=0, Q_LEVEL=0, Q_N=1, Q_PULSE=0. EVT_CNT is preserved.
- CLR_CNT=1 and a qualifying edge in the same cycle: EVT_CNT=1 (clear, then count). CLR_CNT alone sets EVT_CNT=0.
- EVT_CNT wraps from 2^EVT_W-1 to 0.
- Counters must not overflow: with L and H at most 2^CNT_W-1, run and hcnt never exceed their limits.
- Timing, edge 0 = first edge sampling D_IN high, held high:
  - s2 is first seen at edge 2.
  - ASSERT is entered at edge L+1, and Q_PULSE is high during the cycle following edge L+1.

Test Plan:
- Reset mid-ASSERT: L=4, D_IN held high, RESETN low at edge 8 -> after that edge STATE=0, Q_LEVEL=0, Q_N=1, EVT_CNT=0.
- Basic qualify: L=4, H=3, D_IN high from edge 0 -> Q_PULSE high only after edge 5, Q_LEVEL high from edge 5, EVT_CNT=1.
- Glitch reject: L=4, D_IN high for 3 edges then low -> STATE goes 0→1→0, Q_PULSE never asserts, EVT_CNT=0.
- Hold-off: L=2, H=5, D_IN high 10 cycles, low 1 cycle, high again -> exactly 5 HOLDOFF cycles, second pulse 2 cycles after IDLE re-entry, EVT_CNT=2.
- Zero config and config change while BUSY: QUAL_LEN=0 -> ASSERT one edge after s2 first high. Changing QUAL_LEN from 4 to 8 during COUNT still qualifies at 4.
- EN drop and counter edges: EN low during COUNT -> IDLE next edge with EVT_CNT unchanged. EVT_CNT=255 plus one event -> 0. CLR_CNT coincident with a qualify edge -> EVT_CNT=1.

Source files
------------

// File: rtl/din_qualify_ctrl.sv
// Purpose: synchronise D_IN, qualify it with a run-length filter, strobe/hold the capture path, then hold off.
// Latency: 2-cycle synchroniser, then qualification L cycles later; all outputs registered at the state edge.
// Backpressure: none; free-running controller, EN low returns it to IDLE on the next edge.
module din_qualify_ctrl #(
    parameter int CNT_W = 8,
    parameter int EVT_W = 8
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic             EN,
    input  logic             D_IN,
    input  logic [CNT_W-1:0] QUAL_LEN,
    input  logic [CNT_W-1:0] HOLD_LEN,
    input  logic             CLR_CNT,
    output logic             Q_PULSE,
    output logic             Q_LEVEL,
    output logic             Q_N,
    output logic             BUSY,
    output logic [1:0]       STATE,
    output logic [EVT_W-1:0] EVT_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COUNT   = 2'd1,
        ST_ASSERT  = 2'd2,
        ST_HOLDOFF = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [EVT_W-1:0] EVT_ONE = {{(EVT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic             s1_q, s2_q;
    logic [CNT_W-1:0] run_q, run_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] l_q, l_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] run_inc;
    logic [CNT_W-1:0] qual_eff;
    logic [CNT_W-1:0] hold_eff;
    logic             pulse_d;
    logic             level_d;
    logic             qualify;
    logic [EVT_W-1:0] evt_d;

    // A zero length means "one cycle" so the filter and hold-off can never stall.
    assign qual_eff = (QUAL_LEN == '0) ? CNT_ONE : QUAL_LEN;
    assign hold_eff = (HOLD_LEN == '0) ? CNT_ONE : HOLD_LEN;
    assign run_inc  = run_q + CNT_ONE;

    // Two-flop synchroniser for the asynchronous raw input.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= D_IN;
            s2_q <= s1_q;
        end
    end

    // Next-state, counter and output decode; EN low wins over every state.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        hcnt_d  = hcnt_q;
        l_d     = l_q;
        h_d     = h_q;
        pulse_d = 1'b0;
        level_d = Q_LEVEL;
        qualify = 1'b0;

        if (!EN) begin
            state_d = ST_IDLE;
            run_d   = '0;
            hcnt_d  = '0;
            level_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s2_q) begin
                        // Config is frozen here for the whole busy period.
                        l_d = qual_eff;
                        h_d = hold_eff;
                        if (qual_eff == CNT_ONE) begin
                            state_d = ST_ASSERT;
                            qualify = 1'b1;
                        end else begin
                            state_d = ST_COUNT;
                            run_d   = CNT_ONE;
                        end
                    end
                end
                ST_COUNT: begin
                    if (!s2_q) begin
                        state_d = ST_IDLE;
                        run_d   = '0;
                    end else if (run_inc == l_q) begin
                        state_d = ST_ASSERT;
                        run_d   = '0;
                        qualify = 1'b1;
                    end else begin
                        run_d = run_inc;
                    end
                end
                ST_ASSERT: begin
                    if (!s2_q) begin
                        state_d = ST_HOLDOFF;
                        hcnt_d  = CNT_ONE;
                        level_d = 1'b0;
                    end
                end
                ST_HOLDOFF: begin
                    // Input is ignored; exactly H cycles are spent here.
                    if (hcnt_q == h_q) begin
                        state_d = ST_IDLE;
                        hcnt_d  = '0;
                    end else begin
                        hcnt_d = hcnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        if (qualify) begin
            pulse_d = 1'b1;
            level_d = 1'b1;
        end

        // Clear first, then count, so a coincident clear and qualify leaves one.
        evt_d = EVT_CNT;
        if (CLR_CNT) begin
            evt_d = '0;
        end
        if (qualify) begin
            evt_d = evt_d + EVT_ONE;
        end
    end

    // State, counters, latched config and registered outputs all update together.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q <= ST_IDLE;
            run_q   <= '0;
            hcnt_q  <= '0;
            l_q     <= CNT_ONE;
            h_q     <= CNT_ONE;
            Q_PULSE <= 1'b0;
            Q_LEVEL <= 1'b0;
            Q_N     <= 1'b1;
            BUSY    <= 1'b0;
            EVT_CNT <= '0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            hcnt_q  <= hcnt_d;
            l_q     <= l_d;
            h_q     <= h_d;
            Q_PULSE <= pulse_d;
            Q_LEVEL <= level_d;
            Q_N     <= ~level_d;
            BUSY    <= (state_d != ST_IDLE);
            EVT_CNT <= evt_d;
        end
    end

    assign STATE = state_q;

endmodule

// File: tb/tb_din_qualify_ctrl.sv
module tb_din_qualify_ctrl;

    logic       CLK;
    logic       RESETN;
    logic       EN;
    logic       D_IN;
    logic [7:0] QUAL_LEN;
    logic [7:0] HOLD_LEN;
    logic       CLR_CNT;
    logic       Q_PULSE;
    logic       Q_LEVEL;
    logic       Q_N;
    logic       BUSY;
    logic [1:0] STATE;
    logic [7:0] EVT_CNT;

    int tests;
    int fails;
    int exp_evt;

    typedef struct {
        logic       en;
        logic       d;
        logic [7:0] ql;
        logic [7:0] hl;
        logic       clr;
        logic [1:0] st;
        logic       p;
        logic       l;
        logic       b;
        logic [7:0] e;
    } vec_t;

    vec_t vecs[$];

    din_qualify_ctrl #(.CNT_W(8), .EVT_W(8)) dut (
        .CLK      (CLK),
        .RESETN   (RESETN),
        .EN       (EN),
        .D_IN     (D_IN),
        .QUAL_LEN (QUAL_LEN),
        .HOLD_LEN (HOLD_LEN),
        .CLR_CNT  (CLR_CNT),
        .Q_PULSE  (Q_PULSE),
        .Q_LEVEL  (Q_LEVEL),
        .Q_N      (Q_N),
        .BUSY     (BUSY),
        .STATE    (STATE),
        .EVT_CNT  (EVT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic en, input logic d, input logic [7:0] ql, input logic [7:0] hl,
                       input logic clr, input logic [1:0] st, input logic p, input logic l,
                       input logic b, input logic [7:0] e);
        vec_t v;
        v.en = en; v.d = d; v.ql = ql; v.hl = hl; v.clr = clr;
        v.st = st; v.p = p; v.l = l; v.b = b; v.e = e;
        vecs.push_back(v);
    endtask

    task automatic go_idle();
        D_IN = 1'b0;
        repeat (8) tick();
        chk("go_idle_state", STATE, 0);
        chk("go_idle_busy", BUSY, 0);
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        RESETN   = 1'b0;
        EN       = 1'b1;
        D_IN     = 1'b0;
        QUAL_LEN = 8'd4;
        HOLD_LEN = 8'd3;
        CLR_CNT  = 1'b0;

        // Basic qualify: L=4, H=3
        for (int i = 0; i < 2; i++) add(1, 1, 4, 3, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) add(1, 1, 4, 3, 0, 1, 0, 0, 1, 0);
        add(1, 1, 4, 3, 0, 2, 1, 1, 1, 1);
        add(1, 1, 4, 3, 0, 2, 0, 1, 1, 1);
        add(1, 0, 4, 3, 0, 2, 0, 1, 1, 1);
        add(1, 0, 4, 3, 0, 2, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) add(1, 0, 4, 3, 0, 3, 0, 0, 1, 1);
        for (int i = 0; i < 2; i++) add(1, 0, 4, 3, 0, 0, 0, 0, 0, 1);
        // Glitch reject: three high samples with L=4
        for (int i = 0; i < 2; i++) add(1, 1, 4, 3, 0, 0, 0, 0, 0, 1);
        add(1, 1, 4, 3, 0, 1, 0, 0, 1, 1);
        add(1, 0, 4, 3, 0, 1, 0, 0, 1, 1);
        add(1, 0, 4, 3, 0, 1, 0, 0, 1, 1);
        for (int i = 0; i < 2; i++) add(1, 0, 4, 3, 0, 0, 0, 0, 0, 1);
        // Hold-off: L=2, H=5, high 10, low 1, high again
        for (int i = 0; i < 2; i++) add(1, 1, 2, 5, 0, 0, 0, 0, 0, 1);
        add(1, 1, 2, 5, 0, 1, 0, 0, 1, 1);
        add(1, 1, 2, 5, 0, 2, 1, 1, 1, 2);
        for (int i = 0; i < 6; i++) add(1, 1, 2, 5, 0, 2, 0, 1, 1, 2);
        add(1, 0, 2, 5, 0, 2, 0, 1, 1, 2);
        add(1, 1, 2, 5, 0, 2, 0, 1, 1, 2);
        for (int i = 0; i < 5; i++) add(1, 1, 2, 5, 0, 3, 0, 0, 1, 2);
        add(1, 1, 2, 5, 0, 0, 0, 0, 0, 2);
        add(1, 1, 2, 5, 0, 1, 0, 0, 1, 2);
        add(1, 1, 2, 5, 0, 2, 1, 1, 1, 3);
        add(1, 0, 2, 5, 0, 2, 0, 1, 1, 3);
        add(1, 0, 2, 5, 0, 2, 0, 1, 1, 3);
        for (int i = 0; i < 5; i++) add(1, 0, 2, 5, 0, 3, 0, 0, 1, 3);
        add(1, 0, 2, 5, 0, 0, 0, 0, 0, 3);

        // Reset state
        repeat (2) tick();
        chk("rst_state", STATE, 0);
        chk("rst_pulse", Q_PULSE, 0);
        chk("rst_level", Q_LEVEL, 0);
        chk("rst_qn", Q_N, 1);
        chk("rst_busy", BUSY, 0);
        chk("rst_evt", EVT_CNT, 0);
        RESETN = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            EN       = vecs[i].en;
            D_IN     = vecs[i].d;
            QUAL_LEN = vecs[i].ql;
            HOLD_LEN = vecs[i].hl;
            CLR_CNT  = vecs[i].clr;
            tick();
            chk($sformatf("vec%0d_state", i), STATE, vecs[i].st);
            chk($sformatf("vec%0d_pulse", i), Q_PULSE, vecs[i].p);
            chk($sformatf("vec%0d_level", i), Q_LEVEL, vecs[i].l);
            chk($sformatf("vec%0d_qn", i), Q_N, vecs[i].l ? 0 : 1);
            chk($sformatf("vec%0d_busy", i), BUSY, vecs[i].b);
            chk($sformatf("vec%0d_evt", i), EVT_CNT, vecs[i].e);
        end
        exp_evt  = 3;
        HOLD_LEN = 8'd1;

        // Zero QUAL_LEN: ASSERT on the first edge s2 is seen high
        QUAL_LEN = 8'd0;
        D_IN     = 1'b1;
        tick();
        tick();
        chk("zero_edge1_state", STATE, 0);
        tick();
        chk("zero_edge2_state", STATE, 2);
        chk("zero_edge2_pulse", Q_PULSE, 1);
        exp_evt++;
        chk("zero_evt", EVT_CNT, exp_evt);
        go_idle();

        // QUAL_LEN change during COUNT is ignored until the next IDLE exit
        QUAL_LEN = 8'd4;
        D_IN     = 1'b1;
        repeat (3) tick();
        chk("cfg_edge2_state", STATE, 1);
        QUAL_LEN = 8'd8;
        repeat (2) tick();
        chk("cfg_edge4_state", STATE, 1);
        tick();
        chk("cfg_edge5_state", STATE, 2);
        chk("cfg_edge5_pulse", Q_PULSE, 1);
        exp_evt++;
        chk("cfg_evt", EVT_CNT, exp_evt);
        QUAL_LEN = 8'd4;
        go_idle();

        // EN drop during COUNT
        D_IN = 1'b1;
        repeat (3) tick();
        chk("en_pre_state", STATE, 1);
        EN = 1'b0;
        tick();
        chk("en_drop_state", STATE, 0);
        chk("en_drop_busy", BUSY, 0);
        chk("en_drop_level", Q_LEVEL, 0);
        chk("en_drop_qn", Q_N, 1);
        chk("en_drop_evt", EVT_CNT, exp_evt);
        EN = 1'b1;
        go_idle();
        chk("en_after_evt", EVT_CNT, exp_evt);

        // CLR_CNT coincident with the qualifying edge
        D_IN = 1'b1;
        repeat (5) tick();
        chk("clr_pre_state", STATE, 1);
        CLR_CNT = 1'b1;
        tick();
        CLR_CNT = 1'b0;
        chk("clr_q_state", STATE, 2);
        chk("clr_q_evt", EVT_CNT, 1);
        go_idle();
        // CLR_CNT alone
        CLR_CNT = 1'b1;
        tick();
        CLR_CNT = 1'b0;
        chk("clr_only_evt", EVT_CNT, 0);

        // Reset mid-ASSERT at edge 8
        D_IN = 1'b1;
        repeat (8) tick();
        chk("rstm_pre_state", STATE, 2);
        chk("rstm_pre_evt", EVT_CNT, 1);
        RESETN = 1'b0;
        tick();
        chk("rstm_state", STATE, 0);
        chk("rstm_level", Q_LEVEL, 0);
        chk("rstm_qn", Q_N, 1);
        chk("rstm_busy", BUSY, 0);
        chk("rstm_pulse", Q_PULSE, 0);
        chk("rstm_evt", EVT_CNT, 0);
        RESETN = 1'b1;
        go_idle();

        // EVT_CNT wrap: 255 events then one more
        QUAL_LEN = 8'd1;
        HOLD_LEN = 8'd1;
        for (int n = 0; n < 256; n++) begin
            D_IN = 1'b1;
            repeat (3) tick();
            D_IN = 1'b0;
            repeat (5) tick();
            if (n == 254) chk("wrap_255", EVT_CNT, 255);
        end
        chk("wrap_0", EVT_CNT, 0);
        chk("wrap_state", STATE, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
